// File: rtl/multi_bank_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : multi_bank_port_arbiter
// Purpose  : Two-port front end for the 4 x 8 x 8-bit multi-bank memory
//            controller. It arbitrates ports A and B round-robin, supports a
//            bounded lock for read-modify-write sequences, issues one
//            registered memory command per accept, and routes each read
//            response back to its issuing port in order.
// Ports    : clk_pi, rst_pi             - clock, synchronous active-high reset
//            {a,b}_valid_i/_ready_o     - request handshake (ready is comb.)
//            {a,b}_we_i/_lock_i         - write select, lock request/continue
//            {a,b}_addr_i/_wdata_i      - [4:3] bank, [2:0] location; wdata
//            {a,b}_rsp_valid_o/_rdata_o - one-cycle read response
//            mem_en_o/we_o/addr_o/wdata_o, mem_rdata_i - memory port
//            busy_o                     - reads in flight or lock held
// Revision : 1.0 - initial release
// ============================================================================
module multi_bank_port_arbiter #(
    parameter int READ_LAT = 1,   // memory read latency, 1..4
    parameter int LOCK_MAX = 4    // max consecutive locked grants, 2..15
) (
    input  logic       clk_pi,
    input  logic       rst_pi,
    input  logic       a_valid_i,
    output logic       a_ready_o,
    input  logic       a_we_i,
    input  logic       a_lock_i,
    input  logic [4:0] a_addr_i,
    input  logic [7:0] a_wdata_i,
    output logic       a_rsp_valid_o,
    output logic [7:0] a_rdata_o,
    input  logic       b_valid_i,
    output logic       b_ready_o,
    input  logic       b_we_i,
    input  logic       b_lock_i,
    input  logic [4:0] b_addr_i,
    input  logic [7:0] b_wdata_i,
    output logic       b_rsp_valid_o,
    output logic [7:0] b_rdata_o,
    output logic       mem_en_o,
    output logic       mem_we_o,
    output logic [4:0] mem_addr_o,
    output logic [7:0] mem_wdata_o,
    input  logic [7:0] mem_rdata_i,
    output logic       busy_o
);

    localparam logic [1:0] c_ST_RR     = 2'd0;
    localparam logic [1:0] c_ST_LOCK_A = 2'd1;
    localparam logic [1:0] c_ST_LOCK_B = 2'd2;
    localparam logic [3:0] c_LOCK_MAX  = 4'(LOCK_MAX);

    logic [1:0]        r_state;
    logic              r_ptr;        // 0 = A has priority, 1 = B
    logic [3:0]        r_lock_cnt;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [4:0]        r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic [READ_LAT:0] r_pipe_vld;   // read in flight, one bit per cycle
    logic [READ_LAT:0] r_pipe_id;    // owning port: 0 = A, 1 = B
    logic              r_a_rsp;
    logic              r_b_rsp;
    logic [7:0]        r_a_rdata;
    logic [7:0]        r_b_rdata;

    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_acc;
    logic              w_sel_we;
    logic              w_acc_rd;
    logic [3:0]        w_cnt_inc;
    logic              w_tail_vld;
    logic              w_tail_id;

    // Grant selection; nothing is granted while reset is asserted.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!rst_pi) begin
            case (r_state)
                c_ST_RR: begin
                    w_gnt_a = a_valid_i & (~b_valid_i | ~r_ptr);
                    w_gnt_b = b_valid_i & (~a_valid_i |  r_ptr);
                end
                c_ST_LOCK_A: w_gnt_a = a_valid_i;
                c_ST_LOCK_B: w_gnt_b = b_valid_i;
                default: begin
                    w_gnt_a = 1'b0;
                    w_gnt_b = 1'b0;
                end
            endcase
        end
    end

    assign w_acc      = w_gnt_a | w_gnt_b;
    assign w_sel_we   = w_gnt_b ? b_we_i : a_we_i;
    assign w_acc_rd   = w_acc & ~w_sel_we;
    assign w_cnt_inc  = r_lock_cnt + 4'd1;
    assign w_tail_vld = r_pipe_vld[READ_LAT];
    assign w_tail_id  = r_pipe_id[READ_LAT];

    // Arbitration state. Leaving a lock for any reason hands priority to the
    // other port so a locking master cannot starve its peer.
    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            r_state    <= c_ST_RR;
            r_ptr      <= 1'b0;
            r_lock_cnt <= 4'd0;
        end else begin
            case (r_state)
                c_ST_RR: begin
                    if (w_gnt_a) begin
                        r_ptr <= 1'b1;
                        if (a_lock_i) begin
                            r_state    <= c_ST_LOCK_A;
                            r_lock_cnt <= 4'd1;
                        end
                    end else if (w_gnt_b) begin
                        r_ptr <= 1'b0;
                        if (b_lock_i) begin
                            r_state    <= c_ST_LOCK_B;
                            r_lock_cnt <= 4'd1;
                        end
                    end
                end
                c_ST_LOCK_A: begin
                    if (a_valid_i && a_lock_i && (w_cnt_inc != c_LOCK_MAX)) begin
                        r_lock_cnt <= w_cnt_inc;
                    end else begin
                        r_state    <= c_ST_RR;
                        r_ptr      <= 1'b1;
                        r_lock_cnt <= 4'd0;
                    end
                end
                c_ST_LOCK_B: begin
                    if (b_valid_i && b_lock_i && (w_cnt_inc != c_LOCK_MAX)) begin
                        r_lock_cnt <= w_cnt_inc;
                    end else begin
                        r_state    <= c_ST_RR;
                        r_ptr      <= 1'b0;
                        r_lock_cnt <= 4'd0;
                    end
                end
                default: begin
                    r_state    <= c_ST_RR;
                    r_ptr      <= 1'b0;
                    r_lock_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Memory command, read-tracking pipe and response registers. The pipe
    // tail lines up with the cycle in which mem_rdata_i is valid.
    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 5'd0;
            r_mem_wdata <= 8'd0;
            r_pipe_vld  <= '0;
            r_pipe_id   <= '0;
            r_a_rsp     <= 1'b0;
            r_b_rsp     <= 1'b0;
            r_a_rdata   <= 8'd0;
            r_b_rdata   <= 8'd0;
        end else begin
            r_mem_en <= w_acc;
            if (w_acc) begin
                r_mem_we    <= w_sel_we;
                r_mem_addr  <= w_gnt_b ? b_addr_i  : a_addr_i;
                r_mem_wdata <= w_gnt_b ? b_wdata_i : a_wdata_i;
            end
            r_pipe_vld <= {r_pipe_vld[READ_LAT-1:0], w_acc_rd};
            r_pipe_id  <= {r_pipe_id[READ_LAT-1:0], w_gnt_b};
            r_a_rsp    <= w_tail_vld & ~w_tail_id;
            r_b_rsp    <= w_tail_vld &  w_tail_id;
            if (w_tail_vld && !w_tail_id) r_a_rdata <= mem_rdata_i;
            if (w_tail_vld &&  w_tail_id) r_b_rdata <= mem_rdata_i;
        end
    end

    assign a_ready_o     = w_gnt_a;
    assign b_ready_o     = w_gnt_b;
    assign mem_en_o      = r_mem_en;
    assign mem_we_o      = r_mem_we;
    assign mem_addr_o    = r_mem_addr;
    assign mem_wdata_o   = r_mem_wdata;
    assign a_rsp_valid_o = r_a_rsp;
    assign b_rsp_valid_o = r_b_rsp;
    assign a_rdata_o     = r_a_rdata;
    assign b_rdata_o     = r_b_rdata;
    assign busy_o        = (|r_pipe_vld) | (r_state != c_ST_RR);

endmodule
`default_nettype wire

// File: tb/tb_multi_bank_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_bank_port_arbiter
// Purpose  : Self-checking bench for multi_bank_port_arbiter. A behavioural
//            memory answers commands; a transaction-level model predicts
//            grants, commands, responses and busy every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_bank_port_arbiter;

    localparam int RL = 1;
    localparam int LM = 4;

    logic       clk_pi = 1'b0;
    logic       rst_pi;
    logic       a_valid_i, a_we_i, a_lock_i;
    logic [4:0] a_addr_i;
    logic [7:0] a_wdata_i;
    logic       b_valid_i, b_we_i, b_lock_i;
    logic [4:0] b_addr_i;
    logic [7:0] b_wdata_i;
    logic       a_ready_o, b_ready_o, a_rsp_valid_o, b_rsp_valid_o;
    logic [7:0] a_rdata_o, b_rdata_o;
    logic       mem_en_o, mem_we_o, busy_o;
    logic [4:0] mem_addr_o;
    logic [7:0] mem_wdata_o, mem_rdata_i;

    always #5 clk_pi = ~clk_pi;

    multi_bank_port_arbiter #(.READ_LAT(RL), .LOCK_MAX(LM)) dut (
        .clk_pi(clk_pi), .rst_pi(rst_pi),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_we_i(a_we_i),
        .a_lock_i(a_lock_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
        .a_rsp_valid_o(a_rsp_valid_o), .a_rdata_o(a_rdata_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_we_i(b_we_i),
        .b_lock_i(b_lock_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
        .b_rsp_valid_o(b_rsp_valid_o), .b_rdata_o(b_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    // Behavioural memory: data for a read command appears RL cycles later.
    logic [7:0] mem     [0:31];
    logic [7:0] rd_line [0:RL-1];
    assign mem_rdata_i = rd_line[RL-1];
    always @(posedge clk_pi) begin
        if (mem_en_o && mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
        rd_line[0] <= mem[mem_addr_o];
        for (int i = 1; i < RL; i++) rd_line[i] <= rd_line[i-1];
    end

    // Reference model state
    typedef struct { int acc; int due; bit port; logic [7:0] data; } rsp_t;
    rsp_t       q[$];
    logic [7:0] shadow [0:31];
    int         m_owner;   // 0 none, 1 A, 2 B
    int         m_grants;
    int         m_turn;    // 0 A, 1 B
    bit         m_ga, m_gb;
    logic       e_en, e_we;
    logic [4:0] e_addr;
    logic [7:0] e_wdata, e_rdata_a, e_rdata_b;
    int         cyc;
    int         checks, errors;
    bit         t_en;
    logic       t_ra, t_rb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic awe, input logic alk,
                         input logic [4:0] aad, input logic [7:0] awd,
                         input logic bv, input logic bwe, input logic blk,
                         input logic [4:0] bad, input logic [7:0] bwd);
        rst_pi = r;
        a_valid_i = av; a_we_i = awe; a_lock_i = alk; a_addr_i = aad; a_wdata_i = awd;
        b_valid_i = bv; b_we_i = bwe; b_lock_i = blk; b_addr_i = bad; b_wdata_i = bwd;
    endtask

    // Called at a falling edge with inputs set; checks this cycle, advances
    // the model across the next rising edge, returns at the next falling edge.
    task automatic step();
        bit ga, gb, rva, rvb, lk;
        logic [4:0] ad;
        #1;
        ga = 0; gb = 0;
        if (!rst_pi) begin
            if (m_owner == 1)      ga = a_valid_i;
            else if (m_owner == 2) gb = b_valid_i;
            else if (a_valid_i && b_valid_i) begin
                if (m_turn == 0) ga = 1; else gb = 1;
            end else begin
                ga = a_valid_i; gb = b_valid_i;
            end
        end
        m_ga = ga; m_gb = gb;
        chk("a_ready", a_ready_o, ga);
        chk("b_ready", b_ready_o, gb);
        if (t_en) begin
            chk("tbl_a_ready", a_ready_o, t_ra);
            chk("tbl_b_ready", b_ready_o, t_rb);
        end
        chk("mem_en", mem_en_o, e_en);
        chk("mem_we", mem_we_o, e_we);
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_wdata", mem_wdata_o, e_wdata);
        rva = 0; rvb = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].port) begin rvb = 1; e_rdata_b = q[0].data; end
            else           begin rva = 1; e_rdata_a = q[0].data; end
            void'(q.pop_front());
        end
        chk("a_rsp_valid", a_rsp_valid_o, rva);
        chk("b_rsp_valid", b_rsp_valid_o, rvb);
        chk("a_rdata", a_rdata_o, e_rdata_a);
        chk("b_rdata", b_rdata_o, e_rdata_b);
        chk("busy", busy_o, (m_owner != 0) || (q.size() > 0));
        if (rst_pi) begin
            m_owner = 0; m_turn = 0; m_grants = 0; q.delete();
            e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_rdata_a = 0; e_rdata_b = 0;
        end else begin
            e_en = ga | gb;
            if (ga | gb) begin
                e_we    = gb ? b_we_i : a_we_i;
                ad      = gb ? b_addr_i : a_addr_i;
                e_addr  = ad;
                e_wdata = gb ? b_wdata_i : a_wdata_i;
                if (e_we) shadow[ad] = e_wdata;
                else q.push_back('{cyc, cyc + 2 + RL, gb, shadow[ad]});
            end
            lk = gb ? b_lock_i : a_lock_i;
            if (m_owner != 0) begin
                if ((ga | gb) && lk && (m_grants + 1 < LM)) m_grants++;
                else begin
                    m_turn = (m_owner == 1) ? 1 : 0;
                    m_owner = 0; m_grants = 0;
                end
            end else if (ga | gb) begin
                m_turn = ga ? 1 : 0;
                if (lk) begin m_owner = ga ? 1 : 2; m_grants = 1; end
            end
        end
        @(negedge clk_pi);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0,0,0,5'h00,8'h00, 0,0,0,5'h00,8'h00);
            step();
        end
    endtask

    typedef struct {
        logic r;
        logic av, awe, alk; logic [4:0] aad; logic [7:0] awd;
        logic bv, bwe, blk; logic [4:0] bad; logic [7:0] bwd;
        logic era, erb;
    } vec_t;
    vec_t tbl [0:17];

    bit         pa_v, pa_we, pa_lk, pb_v, pb_we, pb_lk;
    logic [4:0] pa_ad, pb_ad;
    logic [7:0] pa_wd, pb_wd;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 8'($urandom);
            shadow[i] = mem[i];
        end
        for (int i = 0; i < RL; i++) rd_line[i] = 8'h00;
        checks = 0; errors = 0; cyc = 0; t_en = 0; t_ra = 0; t_rb = 0;
        m_owner = 0; m_grants = 0; m_turn = 0; m_ga = 0; m_gb = 0;
        e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_rdata_a = 0; e_rdata_b = 0;

        //         r  av we lk aad    awd     bv we lk bad    bwd     ra rb
        tbl[0]  = '{1, 1,0,0,5'h0A,8'h00, 1,0,0,5'h1B,8'h00, 0,0};
        tbl[1]  = '{1, 1,0,0,5'h0A,8'h00, 1,0,0,5'h1B,8'h00, 0,0};
        tbl[2]  = '{0, 1,1,0,5'h0A,8'h5C, 1,1,0,5'h1B,8'h77, 1,0};
        tbl[3]  = '{0, 1,1,0,5'h03,8'h11, 1,1,0,5'h1B,8'h77, 0,1};
        tbl[4]  = '{0, 1,1,0,5'h03,8'h11, 1,0,0,5'h1B,8'h00, 1,0};
        tbl[5]  = '{0, 1,0,0,5'h0A,8'h00, 1,0,0,5'h1B,8'h00, 0,1};
        tbl[6]  = '{0, 1,0,0,5'h0A,8'h00, 0,0,0,5'h00,8'h00, 1,0};
        tbl[7]  = '{0, 0,0,0,5'h00,8'h00, 0,0,0,5'h00,8'h00, 0,0};
        tbl[8]  = '{0, 1,1,1,5'h12,8'hA1, 0,0,0,5'h00,8'h00, 1,0};
        tbl[9]  = '{0, 1,1,1,5'h13,8'hA2, 1,0,0,5'h03,8'h00, 1,0};
        tbl[10] = '{0, 1,0,1,5'h12,8'h00, 1,0,0,5'h03,8'h00, 1,0};
        tbl[11] = '{0, 1,1,1,5'h14,8'hA4, 1,0,0,5'h03,8'h00, 1,0};
        tbl[12] = '{0, 1,0,1,5'h13,8'h00, 1,0,0,5'h03,8'h00, 0,1};
        tbl[13] = '{0, 1,0,1,5'h13,8'h00, 1,0,0,5'h1B,8'h00, 1,0};
        tbl[14] = '{0, 1,1,0,5'h15,8'hA5, 1,0,0,5'h1B,8'h00, 1,0};
        tbl[15] = '{0, 1,0,0,5'h14,8'h00, 1,0,0,5'h1B,8'h00, 0,1};
        tbl[16] = '{0, 1,0,0,5'h14,8'h00, 0,0,0,5'h00,8'h00, 1,0};
        tbl[17] = '{0, 0,0,0,5'h00,8'h00, 0,0,0,5'h00,8'h00, 0,0};

        drive(1, 0,0,0,5'h00,8'h00, 0,0,0,5'h00,8'h00);
        @(negedge clk_pi);

        t_en = 1;
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].r, tbl[i].av, tbl[i].awe, tbl[i].alk, tbl[i].aad, tbl[i].awd,
                  tbl[i].bv, tbl[i].bwe, tbl[i].blk, tbl[i].bad, tbl[i].bwd);
            t_ra = tbl[i].era; t_rb = tbl[i].erb;
            step();
        end
        t_en = 0;
        idle(5);

        // Lock release: locked read, unlocked write, then B wins next cycle.
        drive(0, 1,0,1,5'h0A,8'h00, 0,0,0,5'h00,8'h00); step();
        chk("lockrel_busy_lock", busy_o, 1'b1);
        drive(0, 1,1,0,5'h06,8'h3E, 1,0,0,5'h03,8'h00); step();
        chk("lockrel_busy_pipe", busy_o, 1'b1);
        drive(0, 0,0,0,5'h00,8'h00, 1,0,0,5'h03,8'h00);
        #1 chk("lockrel_b_ready", b_ready_o, 1'b1);
        step();
        chk("lockrel_a_rsp", a_rsp_valid_o, 1'b1);
        idle(5);
        chk("lockrel_idle_busy", busy_o, 1'b0);

        // Contention: A then B, responses on consecutive cycles.
        drive(0, 1,0,0,5'h03,8'h00, 1,0,0,5'h1B,8'h00); step();
        drive(0, 0,0,0,5'h00,8'h00, 1,0,0,5'h1B,8'h00); step();
        idle(1);
        chk("cont_a_rsp", a_rsp_valid_o, 1'b1);
        idle(1);
        chk("cont_b_rsp", b_rsp_valid_o, 1'b1);
        idle(4);

        // Reset while a read is in flight: response dropped, busy cleared.
        drive(0, 1,0,0,5'h05,8'h00, 0,0,0,5'h00,8'h00); step();
        drive(1, 0,0,0,5'h00,8'h00, 0,0,0,5'h00,8'h00); step();
        chk("rst_mid_busy", busy_o, 1'b0);
        idle(1);
        chk("rst_mid_no_rsp", a_rsp_valid_o, 1'b0);
        idle(3);

        // Randomized traffic; requests are held until granted.
        pa_v = 0; pb_v = 0;
        pa_we = 0; pa_lk = 0; pa_ad = 0; pa_wd = 0;
        pb_we = 0; pb_lk = 0; pb_ad = 0; pb_wd = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pa_v && $urandom_range(3) != 0) begin
                pa_v = 1; pa_we = 1'($urandom_range(1)); pa_lk = ($urandom_range(2) == 0);
                pa_ad = 5'($urandom); pa_wd = 8'($urandom);
            end
            if (!pb_v && $urandom_range(3) != 0) begin
                pb_v = 1; pb_we = 1'($urandom_range(1)); pb_lk = ($urandom_range(2) == 0);
                pb_ad = 5'($urandom); pb_wd = 8'($urandom);
            end
            drive(($urandom_range(79) == 0), pa_v, pa_we, pa_lk, pa_ad, pa_wd,
                  pb_v, pb_we, pb_lk, pb_ad, pb_wd);
            step();
            if (m_ga) pa_v = 0;
            if (m_gb) pb_v = 0;
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_bank_port_arbiter.md
# multi_bank_port_arbiter

Two-port front end for the 32-location, 4-bank (4 x 8 x 8-bit) multi-bank memory controller. It arbitrates between requester ports A and B with round-robin fairness and supports a bounded lock for read-modify-write sequences. It drives a single registered command onto the memory port and routes each read response back to the issuing port in order. It sits directly between the two datapath masters and the memory controller.

## Interface
- READ_LAT, 1: cycles from the memory command cycle to valid `mem_rdata_i`; legal range 1-4.
- LOCK_MAX, 4: maximum consecutive grants to one port while locked; legal range 2-15.

Ports:
- clk_pi  in  1  single clock; all logic on the rising edge
- rst_pi  in  1  synchronous, active-high reset
- a_valid_i / b_valid_i  in  1  request valid
- a_ready_o / b_ready_o  out  1  request accepted this cycle (combinational)
- a_we_i / b_we_i  in  1  1 = write, 0 = read
- a_lock_i / b_lock_i  in  1  request or continue a lock
- a_addr_i / b_addr_i  in  5  [4:3] = bank, [2:0] = location
- a_wdata_i / b_wdata_i  in  8  write data
- a_rsp_valid_o / b_rsp_valid_o  out  1  one-cycle read-response pulse
- a_rdata_o / b_rdata_o  out  8  read data; valid only with rsp_valid
- mem_en_o  out  1  memory enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  5  memory address
- mem_wdata_o  out  8  memory write data
- mem_rdata_i  in  8  memory read data
- busy_o  out  1  read(s) in flight or lock held

## Operation
- Accept: x_valid_i & x_ready_o. At most one port is accepted per cycle. Requests are never queued; a port holds its request until it sees ready.
- FSM states:
  - RR: free arbitration. Only one port valid: that port gets ready. Both valid: the port named by the priority pointer gets ready. After any grant, the pointer moves to the other port.
  - LOCK_A / LOCK_B: only the owner can get ready; the other port's ready = 0.
- RR to LOCK_x: on a grant to x with x_lock_i = 1. Lock count set to 1.
- In LOCK_x:
  - x valid & lock: grant x, count + 1. If count reaches LOCK_MAX, go to RR with the pointer set to the other port.
  - x valid & !lock: grant x (final grant), go to RR with the pointer set to the other port.
  - x not valid: no grant this cycle, go to RR with the pointer set to the other port.
- Command: an accepted request is registered into mem_en_o = 1 plus mem_we_o / mem_addr_o / mem_wdata_o for exactly one cycle. With no accept, mem_en_o = 0 and the other mem outputs hold their last values.
- Response routing:
  - Each accepted read pushes {valid, port id} into a shift pipe of depth READ_LAT + 1.
  - At the pipe tail, mem_rdata_i is registered to the owning port's rdata and its rsp_valid pulses for one cycle. The other port's rsp_valid = 0.
  - Writes produce no response.
  - Responses cannot be stalled; requesters must always accept them.
- Order: the memory is single-ported and commands are issued in order, so a read after a write to the same address returns the new data. No hazard logic is needed.
- busy_o = any pipe entry valid, or state is not RR.

## Timing
- Accept in cycle N -> memory command visible in cycle N+1.
- Read data: memory data in cycle N+1+READ_LAT -> rsp_valid and rdata in cycle N+2+READ_LAT. For READ_LAT = 1, that is cycle N+3.
- Throughput: one accept per cycle. Back-to-back reads return back-to-back, one per cycle, in issue order.
- Both ports valid every cycle in RR with no lock: grants alternate A, B, A, B.
- Reset (rst_pi = 1 at a clock edge):
  - State: RR, pointer = A, lock count = 0.
  - Pipe cleared; in-flight reads are dropped and produce no response.
  - Outputs: all ready = 0 while rst_pi = 1. mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, both rsp_valid, both rdata and busy_o are all 0.
- Reset mid-lock: the lock is released and no grant is issued in any cycle where rst_pi = 1.

## Test plan
- Reset: hold rst_pi for 2 cycles with both ports valid -> no ready, every output 0. After release, with both valid, A is granted first.
- Write then read: A writes addr 5'h0A, data 8'h5C (accepted in N) -> mem_en_o = 1, mem_we_o = 1, mem_addr_o = 0A, mem_wdata_o = 5C in N+1. A then reads 0A (accepted in M) -> a_rsp_valid_o = 1, a_rdata_o = 5C in M+3; b_rsp_valid_o stays 0.
- Contention: A reads 5'h03 and B reads 5'h1B, both valid from cycle N -> A accepted in N, B in N+1. Responses: A in N+3, B in N+4, each carrying the data previously written to that address.
- Lock bound: A holds valid & lock for 6 requests while B stays valid, LOCK_MAX = 4 -> A granted 4 consecutive cycles, then B once, then A resumes.
- Lock release: A sends a locked read, then a write with lock = 0 -> B is granted in the next cycle. busy_o stays 1 until A's read response has been delivered.
- Reset mid-flight: A's read is accepted in N, rst_pi is asserted in N+1 -> no a_rsp_valid_o in N+3, and busy_o = 0 after reset.
